// File: rtl/truth_table_sweeper.sv
// truth_table_sweeper: steps a small combinational circuit through every input vector, captures its truth table and compares it with EXPECT (optional first-fail tracking under `FIRST_FAIL_EN`)
module truth_table_sweeper #(
    parameter int N_IN = 3,
    parameter int SETTLE_CYC = 1,
    parameter logic [(1<<N_IN)-1:0] EXPECT = 8'h80
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   f_in,
    output logic [N_IN-1:0]        vec_out,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [(1<<N_IN)-1:0]   table_out,
    output logic [N_IN:0]          err_cnt,
    output logic [N_IN-1:0]        first_fail,
    output logic                   fail_vld
);
    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;
    state_t state, state_nx;
    logic [3:0] cnt;
    logic [(1<<N_IN)-1:0] table_nx;
    logic mis;
    // state register
    always_ff @(posedge clk)
        if (rst) state <= IDLE;
        else state <= state_nx;
    // next-state selection
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? SETTLE : IDLE;
            SETTLE:  state_nx = (cnt == 4'd0) ? SAMPLE : SETTLE;
            SAMPLE:  state_nx = (vec_out == '1) ? DONE : SETTLE;
            default: state_nx = IDLE;
        endcase
    end
    // table with the current sample merged in, so pass can be judged on the same edge
    always_comb begin
        table_nx = table_out;
        table_nx[vec_out] = f_in;
        mis = f_in != EXPECT[vec_out];
    end
    // sweep datapath and registered status outputs
    always_ff @(posedge clk)
        if (rst) begin
            vec_out <= '0;
            cnt <= '0;
            busy <= 1'b0;
            done <= 1'b0;
            pass <= 1'b0;
            table_out <= '0;
            err_cnt <= '0;
        end else begin
            busy <= state_nx == SETTLE || state_nx == SAMPLE;
            done <= state_nx == DONE;
            case (state)
                IDLE: if (start) begin
                    vec_out <= '0;
                    cnt <= 4'(SETTLE_CYC);
                    table_out <= '0;
                    err_cnt <= '0;
                    pass <= 1'b0;
                end
                SETTLE: if (cnt != 4'd0) cnt <= cnt - 4'd1;
                SAMPLE: begin
                    table_out <= table_nx;
                    if (mis) err_cnt <= err_cnt + 1'b1;
                    if (vec_out != '1) begin
                        vec_out <= vec_out + 1'b1;
                        cnt <= 4'(SETTLE_CYC);
                    end else pass <= table_nx == EXPECT;
                end
                default: ;
            endcase
        end
`ifdef FIRST_FAIL_EN
    // latch the lowest mismatching vector of the sweep
    always_ff @(posedge clk)
        if (rst || (state == IDLE && start)) begin
            first_fail <= '0;
            fail_vld <= 1'b0;
        end else if (state == SAMPLE && mis && !fail_vld) begin
            first_fail <= vec_out;
            fail_vld <= 1'b1;
        end
`else
    assign first_fail = '0;
    assign fail_vld = 1'b0;
`endif
endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb_truth_table_sweeper: random and directed sweeps of truth_table_sweeper checked against a truth-table model
module tb_truth_table_sweeper;
    logic clk = 0, rst = 1, start = 0, start2 = 0;
    logic [7:0] tt = 0;
    logic [3:0] tt2 = 0;
    logic f_in, f_in2;
    logic [2:0] vec_out, first_fail;
    logic busy, done, pass, fail_vld;
    logic [7:0] table_out;
    logic [3:0] err_cnt;
    logic [1:0] vec2, ff2;
    logic busy2, done2, pass2, fv2;
    logic [3:0] tab2;
    logic [2:0] err2;
    int n_chk = 0, n_fail = 0;

    truth_table_sweeper dut (
        .clk(clk), .rst(rst), .start(start), .f_in(f_in), .vec_out(vec_out), .busy(busy), .done(done),
        .pass(pass), .table_out(table_out), .err_cnt(err_cnt), .first_fail(first_fail), .fail_vld(fail_vld)
    );
    truth_table_sweeper #(.N_IN(2), .SETTLE_CYC(0), .EXPECT(4'h8)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .f_in(f_in2), .vec_out(vec2), .busy(busy2), .done(done2),
        .pass(pass2), .table_out(tab2), .err_cnt(err2), .first_fail(ff2), .fail_vld(fv2)
    );

    always #5 clk = ~clk;
    assign f_in = tt[vec_out];
    assign f_in2 = tt2[vec2];

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset();
        check("rst_vec", 32'(vec_out), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_pass", 32'(pass), 0);
        check("rst_table", 32'(table_out), 0);
        check("rst_err", 32'(err_cnt), 0);
        check("rst_ff", 32'(first_fail), 0);
        check("rst_vld", 32'(fail_vld), 0);
    endtask

    task automatic check_result(input logic [7:0] t);
        logic [7:0] d;
        int e, ff;
        d = t ^ 8'h80;
        e = 0;
        ff = -1;
        for (int i = 0; i < 8; i++) if (d[i]) begin
            e++;
            if (ff < 0) ff = i;
        end
        check("table", 32'(table_out), 32'(t));
        check("pass", 32'(pass), 32'(t == 8'h80));
        check("err_cnt", 32'(err_cnt), 32'(e));
        check("vec_last", 32'(vec_out), 7);
`ifdef FIRST_FAIL_EN
        check("first_fail", 32'(first_fail), ff < 0 ? 0 : 32'(ff));
        check("fail_vld", 32'(fail_vld), 32'(ff >= 0));
`else
        check("first_fail", 32'(first_fail), 0);
        check("fail_vld", 32'(fail_vld), 0);
`endif
    endtask

    task automatic sweep(input logic [7:0] t, input bit poke);
        int n;
        tt = t;
        @(negedge clk) start = 1;
        @(posedge clk);
        @(negedge clk) start = 0;
        n = 1;
        check("busy_start", 32'(busy), 1);
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
            if (poke) start = (n == 7);
        end
        start = 0;
        check("done_cycle", 32'(n), 25);
        check("busy_done", 32'(busy), 0);
        check_result(t);
        @(negedge clk);
        check("done_pulse", 32'(done), 0);
        check("table_hold", 32'(table_out), 32'(t));
        check("pass_hold", 32'(pass), 32'(t == 8'h80));
    endtask

    task automatic sweep2(input logic [3:0] t);
        int n, e;
        tt2 = t;
        @(negedge clk) start2 = 1;
        @(posedge clk);
        @(negedge clk) start2 = 0;
        n = 1;
        while (!done2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        e = 0;
        for (int i = 0; i < 4; i++) e += int'(t[i] != (i == 3));
        check("n2_done_cycle", 32'(n), 9);
        check("n2_table", 32'(tab2), 32'(t));
        check("n2_pass", 32'(pass2), 32'(t == 4'h8));
        check("n2_err", 32'(err2), 32'(e));
    endtask

    initial begin
        int d1, d2, nd, late;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset();
        rst = 0;
        sweep(8'h80, 0);
        sweep(8'h96, 0);
        sweep(8'hFF, 1);
        sweep(8'h00, 0);
        repeat (5) sweep(8'($urandom), 1'($urandom));
        // reset in the middle of a sweep
        tt = 8'($urandom);
        @(negedge clk) start = 1;
        @(posedge clk);
        @(negedge clk) start = 0;
        repeat (9) @(negedge clk);
        rst = 1;
        @(negedge clk) rst = 0;
        check_reset();
        nd = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) nd++;
        end
        check("no_done_after_rst", 32'(nd), 0);
        check("idle_after_rst", 32'(busy), 0);
        sweep(8'h80, 0);
        // start held high: back-to-back sweeps
        tt = 8'h96;
        d1 = 0;
        d2 = 0;
        nd = 0;
        @(negedge clk) start = 1;
        @(posedge clk);
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (done) begin
                nd++;
                if (nd == 1) d1 = k;
                if (nd == 2) d2 = k;
            end
        end
        start = 0;
        check("held_done_count", 32'(nd), 2);
        check("held_done1", 32'(d1), 25);
        check("held_done2", 32'(d2), 51);
        late = 0;
        while (!done && late < 100) begin
            @(negedge clk);
            late++;
        end
        check("held_third_done", 32'(done), 1);
        check_result(8'h96);
        @(negedge clk);
        // two-input variant
        sweep2(4'h8);
        sweep2(4'h6);
        sweep2(4'($urandom));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
